// File: rtl/ram_lsu.sv
// Load/store master for a word RAM without byte enables.
// Handles RV32 LB/LBU/LH/LHU/LW/SB/SH/SW, sub-word stores by RMW.
module ram_lsu #(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [1:0]              REQ_SIZE,
  input  logic                    REQ_UNSIGNED,
  input  logic [addr_width+1:0]   REQ_ADDR,
  input  logic [data_width-1:0]   REQ_WDATA,
  output logic                    RSP_VALID,
  output logic [data_width-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [addr_width-1:0]   ADDR_W,
  output logic                    ENABLE_W,
  output logic [data_width-1:0]   Q_W,
  output logic [addr_width-1:0]   ADDR_R,
  input  logic [data_width-1:0]   Q_R
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t state;
  state_t state_nx;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_lane;
  logic [addr_width-1:0] r_word;
  logic [15:0]           r_wdata;
  logic                  r_err;

  logic                  accept;
  logic                  bad;
  logic                  is_sw;
  logic [addr_width-1:0] req_word;
  logic [data_width-1:0] merged;
  logic [data_width-1:0] loaded;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  // Request decode: handshake, alignment and store-word shortcut
  always_comb begin
    accept   = REQ_VALID && (state == IDLE);
    req_word = REQ_ADDR[addr_width+1:2];
    bad      = 1'b0;
    unique case (REQ_SIZE)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = REQ_ADDR[0];
      SZ_W:    bad = |REQ_ADDR[1:0];
      default: bad = 1'b1;
    endcase
    is_sw = REQ_WE && (REQ_SIZE == SZ_W);
  end

  // State register; reset aborts any transfer in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            state_nx = RESP;
          end else if (is_sw) begin
            state_nx = WRITE;
          end else begin
            state_nx = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_nx = RD_DATA;
      RD_DATA: begin
        if (r_we) begin
          state_nx = WRITE;
        end else begin
          state_nx = RESP;
        end
      end
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes decoded from state so reset drops them at once
  always_comb begin
    REQ_READY = (state == IDLE);
    ENABLE_W  = (state == WRITE);
    RSP_VALID = (state == RESP);
    RSP_ERR   = (state == RESP) && r_err;
  end

  // Lane extraction for loads and lane merge for SB/SH
  always_comb begin
    byte_v = Q_R[{r_lane, 3'b000} +: 8];
    half_v = r_lane[1] ? Q_R[31:16] : Q_R[15:0];
    loaded = Q_R;
    unique case (r_size)
      SZ_B: loaded = {{24{~r_uns & byte_v[7]}}, byte_v};
      SZ_H: loaded = {{16{~r_uns & half_v[15]}}, half_v};
      default: loaded = Q_R;
    endcase
    merged = Q_R;
    unique case (r_size)
      SZ_B: merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      SZ_H: begin
        if (r_lane[1]) begin
          merged[31:16] = r_wdata;
        end else begin
          merged[15:0] = r_wdata;
        end
      end
      default: merged = Q_R;
    endcase
  end

  // Request latch and RAM/response datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_uns     <= 1'b0;
      r_lane    <= 2'b00;
      r_word    <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      RSP_RDATA <= '0;
      ADDR_W    <= '0;
      Q_W       <= '0;
      ADDR_R    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            r_we      <= REQ_WE;
            r_size    <= REQ_SIZE;
            r_uns     <= REQ_UNSIGNED;
            r_lane    <= REQ_ADDR[1:0];
            r_word    <= req_word;
            r_wdata   <= REQ_WDATA[15:0];
            r_err     <= bad;
            RSP_RDATA <= '0;
            if (!bad && is_sw) begin
              ADDR_W <= req_word;
              Q_W    <= REQ_WDATA;
            end
            if (!bad && !is_sw) begin
              ADDR_R <= req_word;
            end
          end
        end
        RD_DATA: begin
          if (r_we) begin
            ADDR_W <= r_word;
            Q_W    <= merged;
          end else begin
            RSP_RDATA <= loaded;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Randomised bench for ram_lsu against a word-array reference model.
// Includes a behavioural synchronous-read RAM driven by the DUT.
module tb_ram_lsu;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] addr_w;
  logic          enable_w;
  logic [31:0]   q_w;
  logic [AW-1:0] addr_r;
  logic [31:0]   q_r;

  logic [31:0] ram   [0:(1<<AW)-1];
  logic [31:0] model [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  ram_lsu #(.addr_width(AW), .data_width(32)) dut (
    .CLK(clk), .RESET(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
    .RSP_ERR(rsp_err),
    .ADDR_W(addr_w), .ENABLE_W(enable_w), .Q_W(q_w),
    .ADDR_R(addr_r), .Q_R(q_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enable_w) ram[addr_w] <= q_w;
    q_r <= ram[addr_r];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(logic [1:0] sz, int a);
    if (sz == 2'd3) return 1;
    if (sz == 2'd1 && (a % 2) != 0) return 1;
    if (sz == 2'd2 && (a % 4) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w,
      logic [1:0] sz, logic uns, int lane);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 128) v = v - 32'd256;
    end else begin
      v = (w >> (8 * lane)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w,
      logic [1:0] sz, int lane, logic [31:0] wd);
    logic [31:0] m;
    if (sz == 2'd2) return wd;
    m = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    m = m << (8 * lane);
    return (w & ~m) | ((wd << (8 * lane)) & m);
  endfunction

  task automatic do_req(input string tag, input logic we,
      input logic [1:0] sz, input logic uns,
      input logic [AW+1:0] a, input logic [31:0] wd,
      output logic [31:0] rd, output logic [31:0] wq);
    int wi, lane, lat, nwr, exp_lat, exp_wr, waitc;
    bit err;
    logic [31:0] w, exp_rd, exp_wq;
    logic [AW-1:0] wa;
    wi = int'(a) / 4;
    lane = int'(a) % 4;
    err = is_err(sz, int'(a));
    w = model[wi];
    exp_rd = 32'd0;
    exp_wq = w;
    exp_wr = 0;
    if (err) begin
      exp_lat = 1;
    end else if (we) begin
      exp_wq = ref_store(w, sz, lane, wd);
      exp_wr = 1;
      exp_lat = (sz == 2'd2) ? 2 : 4;
    end else begin
      exp_rd = ref_load(w, sz, uns, lane);
      exp_lat = 3;
    end
    @(negedge clk);
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 0;
    req_wdata = $urandom;
    lat = 0; nwr = 0; wa = '0; wq = '0; rd = '0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (enable_w) begin
        nwr++; wa = addr_w; wq = q_w;
      end
      if (rsp_valid) begin
        lat = c;
        rd = rsp_rdata;
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, rsp_err, err);
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " writes"}, nwr, exp_wr);
    if (exp_wr == 1) begin
      check({tag, " addr_w"}, wa, wi);
      check({tag, " q_w"}, wq, exp_wq);
      model[wi] = exp_wq;
    end
    @(negedge clk);
    check({tag, " pulse"}, rsp_valid, 0);
  endtask

  initial begin
    logic [31:0] rd, wq;
    int lat, n;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = 32'd0;
      model[i] = 32'd0;
    end
    rst = 1; req_valid = 0; req_we = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    #1;
    check("rst enable_w", enable_w, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_err", rsp_err, 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    check("rst q_w", q_w, 0);
    check("rst addr_w", addr_w, 0);
    check("rst addr_r", addr_r, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    do_req("sw4", 1, 2'd2, 0, 12'h004, 32'hDEADBEEF, rd, wq);
    check("sw4 q_w const", wq, 32'hDEADBEEF);

    // Back-to-back LW with REQ_VALID held high
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'd2;
    req_unsigned = 0; req_addr = 12'h004;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) lat = c;
    end
    check("b2b lat", lat, 3);
    check("b2b rdata", rsp_rdata, 32'hDEADBEEF);
    check("b2b ready resp", req_ready, 0);
    @(negedge clk);
    check("b2b ready idle", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 0;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) lat = c;
    end
    check("b2b2 lat", lat, 3);
    check("b2b2 rdata", rsp_rdata, 32'hDEADBEEF);

    do_req("sb6", 1, 2'd0, 0, 12'h006, 32'h55, rd, wq);
    check("sb6 q_w const", wq, 32'hDE55BEEF);
    do_req("lb7", 0, 2'd0, 0, 12'h007, 0, rd, wq);
    check("lb7 const", rd, 32'hFFFFFFDE);
    do_req("lbu7", 0, 2'd0, 1, 12'h007, 0, rd, wq);
    check("lbu7 const", rd, 32'h000000DE);
    do_req("sh2", 1, 2'd1, 0, 12'h002, 32'h8001, rd, wq);
    check("sh2 q_w const", wq, 32'h80010000);
    do_req("lh2", 0, 2'd1, 0, 12'h002, 0, rd, wq);
    check("lh2 const", rd, 32'hFFFF8001);
    do_req("lhu2", 0, 2'd1, 1, 12'h002, 0, rd, wq);
    check("lhu2 const", rd, 32'h00008001);

    do_req("lw5", 0, 2'd2, 0, 12'h005, 0, rd, wq);
    do_req("sh3", 1, 2'd1, 0, 12'h003, 32'h1234, rd, wq);
    do_req("sz3", 1, 2'd3, 0, 12'h004, 32'h1, rd, wq);
    do_req("lw4", 0, 2'd2, 0, 12'h004, 0, rd, wq);
    check("lw4 const", rd, 32'hDE55BEEF);

    // Reset asserted while an SB is in its write cycle
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd0;
    req_addr = 12'h010; req_wdata = 32'hA5;
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (3) @(negedge clk);
    check("abort enable_w hi", enable_w, 1);
    #1;
    rst = 1;
    #1;
    check("abort enable_w lo", enable_w, 0);
    @(negedge clk);
    rst = 0;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("abort no rsp", n, 0);
    check("abort ready", req_ready, 1);
    do_req("sw10", 1, 2'd2, 0, 12'h010, 32'h0BADF00D, rd, wq);
    do_req("lw10", 0, 2'd2, 0, 12'h010, 0, rd, wq);
    check("lw10 const", rd, 32'h0BADF00D);

    for (int i = 0; i < 300; i++) begin
      do_req("rnd", 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             12'($urandom_range(0, 127)), $urandom, rd, wq);
    end

    for (int i = 0; i < 32; i++) begin
      check("ram image", ram[i], model[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
